// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration on {acc, shreg}: LSB-first shift-add for multiply, restoring
// shift-subtract for divide. opnd is the multiplicand or the divisor magnitude.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] shreg_i,
   input  logic [WIDTH-1:0] opnd_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] shreg_o
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum     = {1'b0, acc_i} + {1'b0, opnd_i};
      shifted = {acc_i, shreg_i[WIDTH-1]};
      // The true difference is below the divisor whenever it is used, so WIDTH bits suffice.
      diff    = shifted[WIDTH-1:0] - opnd_i;
      if (is_div) begin
         if (shifted >= {1'b0, opnd_i}) begin
            acc_o   = diff;
            shreg_o = {shreg_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o   = shifted[WIDTH-1:0];
            shreg_o = {shreg_i[WIDTH-2:0], 1'b0};
         end
      end else if (shreg_i[0]) begin
         {acc_o, shreg_o} = {sum, shreg_i[WIDTH-1:1]};
      end else begin
         {acc_o, shreg_o} = {1'b0, acc_i, shreg_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/DIV unit with architectural HI/LO. Works on operand magnitudes for
// WIDTH cycles, then applies sign correction in a single FIX cycle.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   acc_q, acc_d, shreg_q, shreg_d, opnd_q, opnd_d;
   logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
   logic               b_zero_q, b_zero_d;

   logic [WIDTH-1:0]   step_acc, step_shreg;
   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] prod;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div_q),
      .acc_i   (acc_q),
      .shreg_i (shreg_q),
      .opnd_i  (opnd_q),
      .acc_o   (step_acc),
      .shreg_o (step_shreg)
   );

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      acc_d      = acc_q;
      shreg_d    = shreg_q;
      opnd_d     = opnd_q;
      is_div_d   = is_div_q;
      neg_lo_d   = neg_lo_q;
      neg_hi_d   = neg_hi_q;
      b_zero_d   = b_zero_q;

      signed_op  = (op == OP_MULT) || (op == OP_DIV);
      a_neg      = signed_op && a[WIDTH-1];
      b_neg      = signed_op && b[WIDTH-1];
      a_mag      = a_neg ? -a : a;
      b_mag      = b_neg ? -b : b;
      prod       = neg_lo_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};

      case (state_q)
         ST_IDLE: begin
            if (start && !flush) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     is_div_d = (op == OP_DIV) || (op == OP_DIVU);
                     acc_d    = '0;
                     cnt_d    = '0;
                     shreg_d  = is_div_d ? a_mag : b_mag;
                     opnd_d   = is_div_d ? b_mag : a_mag;
                     b_zero_d = is_div_d && (b == '0);
                     neg_lo_d = a_neg ^ b_neg;
                     neg_hi_d = is_div_d ? a_neg : (a_neg ^ b_neg);
                     state_d  = ST_RUN;
                  end
                  OP_MTHI: hi_d = a;
                  OP_MTLO: lo_d = a;
                  OP_NONE: ;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            acc_d   = step_acc;
            shreg_d = step_shreg;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            // A zero divisor leaves |a| in acc, so the dividend-sign fix restores a exactly.
            if (is_div_q) begin
               lo_d = b_zero_q ? '1 : (neg_lo_q ? -shreg_q : shreg_q);
               hi_d = neg_hi_q ? -acc_q : acc_q;
            end else begin
               {hi_d, lo_d} = prod;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // NOTE: working registers are always loaded on accept before use, so they carry no reset.
   always_ff @(posedge clk) begin
      acc_q    <= acc_d;
      shreg_q  <= shreg_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      b_zero_q <= b_zero_d;
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance share stimulus; an arithmetic
// reference model with a fixed-latency timing model is compared on every falling edge.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        flush;

   logic        busy32, done32, busy8, done8;
   logic [31:0] hi32, lo32;
   logic [7:0]  hi8, lo8;

   int checks;
   int failures;
   bit chk_en;

   muldiv_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
      .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a[7:0]), .b(b[7:0]), .flush(flush),
      .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Plain arithmetic result of an op at width w, returned as {hi, lo}.
   function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input int w);
      logic [63:0] mask, ux, uy, up, rh, rl;
      longint      sx, sy;
      mask = (64'd1 << w) - 64'd1;
      ux   = {32'd0, x} & mask;
      uy   = {32'd0, y} & mask;
      sx   = ux[w-1] ? longint'(ux) - longint'(64'd1 << w) : longint'(ux);
      sy   = uy[w-1] ? longint'(uy) - longint'(64'd1 << w) : longint'(uy);
      rh   = '0;
      rl   = '0;
      if (o == OP_MULT || o == OP_MULTU) begin
         up = (o == OP_MULT) ? 64'(sx * sy) : ux * uy;
         rl = up & mask;
         rh = (up >> w) & mask;
      end else if (o == OP_DIV || o == OP_DIVU) begin
         if (uy == 0) begin
            rl = mask;
            rh = ux;
         end else if (o == OP_DIV) begin
            rl = 64'(sx / sy) & mask;
            rh = 64'(sx % sy) & mask;
         end else begin
            rl = (ux / uy) & mask;
            rh = (ux % uy) & mask;
         end
      end
      return {rh[31:0], rl[31:0]};
   endfunction

   // Timing model: an accepted op keeps the unit busy for w+1 cycles, then delivers.
   logic [31:0] m_hi[2], m_lo[2];
   logic [63:0] m_pend[2];
   int          m_rem[2];
   logic        m_done[2];
   int          m_w;
   logic [31:0] m_a, m_b;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_w = (k == 0) ? 32 : 8;
         m_a = (k == 0) ? a : {24'd0, a[7:0]};
         m_b = (k == 0) ? b : {24'd0, b[7:0]};
         if (!rst_n) begin
            m_hi[k]   = '0;
            m_lo[k]   = '0;
            m_rem[k]  = 0;
            m_done[k] = 1'b0;
         end else begin
            m_done[k] = 1'b0;
            if (m_rem[k] > 0) begin
               if (flush) m_rem[k] = 0;
               else if (m_rem[k] == 1) begin
                  {m_hi[k], m_lo[k]} = m_pend[k];
                  m_done[k] = 1'b1;
                  m_rem[k]  = 0;
               end else m_rem[k]--;
            end else if (start && !flush) begin
               if (op >= OP_MULT && op <= OP_DIVU) begin
                  m_pend[k] = ref_op(op, m_a, m_b, m_w);
                  m_rem[k]  = m_w + 1;
               end else if (op == OP_MTHI) m_hi[k] = m_a;
               else if (op == OP_MTLO) m_lo[k] = m_a;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("w32 busy", busy32, m_rem[0] > 0);
         check("w32 done", done32, m_done[0]);
         check("w32 hi", hi32, m_hi[0]);
         check("w32 lo", lo32, m_lo[0]);
         check("w8 busy", busy8, m_rem[1] > 0);
         check("w8 done", done8, m_done[1]);
         check("w8 hi", {24'd0, hi8}, m_hi[1]);
         check("w8 lo", {24'd0, lo8}, m_lo[1]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
      op    = OP_NONE;
   endtask

   task automatic run32(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
      int n, bc;
      issue(o, x, y);
      n  = 0;
      bc = busy32 ? 1 : 0;
      while (!done32 && n < 100) begin
         tick();
         n++;
         if (busy32) bc++;
      end
      check({nm, " latency"}, n, 33);
      check({nm, " busy cycles"}, bc, 33);
      check({nm, " hi"}, hi32, eh);
      check({nm, " lo"}, lo32, el);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, dones, r;
      logic [2:0]  o;
      logic [31:0] x, y;
      checks = 0; failures = 0; chk_en = 1'b0;
      rst_n = 1'b0; start = 1'b0; op = OP_NONE; a = '0; b = '0; flush = 1'b0;
      tick();
      tick();
      rst_n  = 1'b1;
      chk_en = 1'b1;
      check("reset hi", hi32, 0);
      check("reset lo", lo32, 0);
      check("reset busy", busy32, 0);

      run32("mult 7*-3", OP_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run32("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run32("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run32("divu by 0", OP_DIVU, 32'd10, 32'd0, 32'h0000_000A, 32'hFFFF_FFFF);
      run32("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      run32("div -9/0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

      issue(OP_MTHI, 32'h1234_5678, 32'd0);
      check("mthi hi", hi32, 32'h1234_5678);
      check("mthi busy", busy32, 0);
      issue(OP_MTLO, 32'h9ABC_DEF0, 32'd0);
      check("mtlo lo", lo32, 32'h9ABC_DEF0);
      check("mtlo done", done32, 0);

      // In-flight MULT: ignored restart at cycle 5, flush at cycle 10.
      issue(OP_MULT, 32'd5, 32'd6);
      repeat (4) tick();
      issue(OP_MULTU, 32'd9, 32'd9);
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush busy", busy32, 0);
      dones = 0;
      repeat (40) begin
         tick();
         if (done32) dones++;
      end
      check("flush no done", dones, 0);
      check("flush hi kept", hi32, 32'h1234_5678);
      check("flush lo kept", lo32, 32'h9ABC_DEF0);

      // Flush landing on the FIX edge discards the result.
      issue(OP_DIVU, 32'd100, 32'd7);
      repeat (32) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush fix done", done32, 0);
      check("flush fix lo", lo32, 32'h9ABC_DEF0);
      repeat (10) tick();

      flush = 1'b1;
      issue(OP_MULT, 32'd2, 32'd3);
      flush = 1'b0;
      check("flush beats start", busy32, 0);
      issue(3'd7, 32'd1, 32'd1);
      check("reserved op busy", busy32, 0);

      issue(OP_MULTU, 32'd3, 32'd4);
      repeat (19) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrun reset hi", hi32, 0);
      check("midrun reset lo", lo32, 0);
      check("midrun reset busy", busy32, 0);

      // Randomized phase driven off the 8-bit instance.
      for (int i = 0; i < 1000; i++) begin
         n = 0;
         while (busy8 && n < 20) begin
            tick();
            n++;
         end
         r = $urandom_range(0, 19);
         x = $urandom;
         y = $urandom;
         if (r == 0) begin
            issue(3'($urandom_range(1, 4)), x, y);
            repeat ($urandom_range(1, 8)) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check("w8 rand flush busy", busy8, 0);
         end else if (r == 1) begin
            o = 3'($urandom_range(0, 3));
            issue((o == 3'd0) ? OP_MTHI : (o == 3'd1) ? OP_MTLO : (o == 3'd2) ? OP_NONE : 3'd7, x, y);
            check("w8 rand move busy", busy8, 0);
         end else begin
            o = 3'($urandom_range(1, 4));
            if (r == 2) y = y & 32'hFFFF_FF00;
            if (r == 3) begin
               x = 32'h0000_0080;
               y = 32'h0000_00FF;
            end
            issue(o, x, y);
            n = 0;
            while (!done8 && n < 30) begin
               tick();
               n++;
            end
            check("w8 rand latency", n, 9);
         end
      end

      repeat (40) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
